// File: rtl/exec_controller_pkg.sv
// Shared encodings and default widths for the run/halt/step execution controller.
package exec_ctrl_pkg;

  localparam int PC_W_DEF   = 7;
  localparam int STEP_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_RUN     = 3'd1,
    CMD_HALT    = 3'd2,
    CMD_STEP    = 3'd3,
    CMD_SET_BP  = 3'd4,
    CMD_CLR_BP  = 3'd5,
    CMD_CLR_CNT = 3'd6,
    CMD_RSVD    = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_BREAK  = 2'd3
  } state_e;

endpackage

// File: rtl/exec_controller_if.sv
// Debug command port: valid/ready handshake carrying an opcode and its argument.
interface exec_controller_if #(
  parameter int STEP_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;

  modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/exec_controller_retire_counter.sv
// Saturating retired-instruction counter; clear takes priority over increment.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/exec_controller.sv
// Run/halt/single-step sequencer producing the CPU advance enable, with one
// PC breakpoint, a step down-counter and a retired-instruction counter.
module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  exec_controller_if.slave cmd,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic             bp_hit,
  output logic             cmd_err,
  output logic [CNT_W-1:0] retired
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              bp_en_q, bp_en_d;
  logic [PC_W-1:0]   bp_addr_q, bp_addr_d;
  logic              skip_bp_q, skip_bp_d;
  logic              bp_hit_q, bp_hit_d;
  logic              cmd_err_q, cmd_err_d;

  cmd_op_e op;
  logic    running;
  logic    bp_now;
  logic    clr_cnt;

  assign cmd.cmd_ready = rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HALTED;
      step_cnt_q <= '0;
      bp_en_q    <= 1'b0;
      bp_addr_q  <= '0;
      skip_bp_q  <= 1'b0;
      bp_hit_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      bp_en_q    <= bp_en_d;
      bp_addr_q  <= bp_addr_d;
      skip_bp_q  <= skip_bp_d;
      bp_hit_q   <= bp_hit_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // skip_bp lets a resume execute the instruction sitting on the breakpoint.
  always_comb begin
    op      = cmd.cmd_valid ? cmd_op_e'(cmd.cmd_op) : CMD_NOP;
    running = (state_q == ST_RUN) || (state_q == ST_STEP);
    bp_now  = bp_en_q && (pc == bp_addr_q) && !skip_bp_q;
    cpu_en  = running && !bp_now;
    halted  = !running;
    clr_cnt = (op == CMD_CLR_CNT);
  end

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    bp_en_d    = bp_en_q;
    bp_addr_d  = bp_addr_q;
    skip_bp_d  = skip_bp_q && !cpu_en;
    bp_hit_d   = 1'b0;
    cmd_err_d  = (op == CMD_RSVD)
               || (running && ((op == CMD_RUN) || (op == CMD_STEP)))
               || (!running && (op == CMD_HALT));

    if (running) begin
      if (op == CMD_HALT) begin
        state_d    = ST_HALTED;
        step_cnt_d = '0;
      end else if (bp_now) begin
        state_d  = ST_BREAK;
        bp_hit_d = 1'b1;
      end else if (state_q == ST_STEP) begin
        step_cnt_d = step_cnt_q - 1'b1;
        if (step_cnt_q == STEP_W'(1)) begin
          state_d = ST_HALTED;
        end
      end
    end else if (op == CMD_RUN) begin
      state_d   = ST_RUN;
      skip_bp_d = 1'b1;
    end else if ((op == CMD_STEP) && (cmd.cmd_arg != '0)) begin
      state_d    = ST_STEP;
      step_cnt_d = cmd.cmd_arg;
      skip_bp_d  = 1'b1;
    end

    if (op == CMD_SET_BP) begin
      bp_en_d   = 1'b1;
      bp_addr_d = cmd.cmd_arg[PC_W-1:0];
    end else if (op == CMD_CLR_BP) begin
      bp_en_d = 1'b0;
    end
  end

  assign state   = state_q;
  assign bp_hit  = bp_hit_q;
  assign cmd_err = cmd_err_q;

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cpu_en),
    .clr   (clr_cnt),
    .count (retired)
  );

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller: a vector table, directed corner
// sequences and randomized commands against a rule-level reference model.
module tb_exec_controller;
  import exec_ctrl_pkg::*;

  localparam int PC_W   = 7;
  localparam int STEP_W = 8;
  localparam int CNT_W  = 16;
  localparam int CNT_S  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [2:0]        cmd_op = 3'd0;
  logic [STEP_W-1:0] cmd_arg = '0;
  logic [PC_W-1:0]   pc = '0;

  logic             cpu_en, halted, bp_hit, cmd_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] retired;
  logic             cpu_en_s, halted_s, bp_hit_s, cmd_err_s;
  logic [1:0]       state_s;
  logic [CNT_S-1:0] retired_s;

  exec_controller_if #(.STEP_W(STEP_W)) cmd_bus ();
  exec_controller_if #(.STEP_W(STEP_W)) cmd_bus_s ();

  assign cmd_bus.cmd_valid   = cmd_valid;
  assign cmd_bus.cmd_op      = cmd_op;
  assign cmd_bus.cmd_arg     = cmd_arg;
  assign cmd_bus_s.cmd_valid = cmd_valid;
  assign cmd_bus_s.cmd_op    = cmd_op;
  assign cmd_bus_s.cmd_arg   = cmd_arg;

  exec_controller #(.PC_W(PC_W), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
    .clk (clk), .rst_n (rst_n), .cmd (cmd_bus.slave), .pc (pc),
    .cpu_en (cpu_en), .state (state), .halted (halted), .bp_hit (bp_hit),
    .cmd_err (cmd_err), .retired (retired)
  );

  // Narrow-counter copy fed identical stimulus to exercise saturation.
  exec_controller #(.PC_W(PC_W), .STEP_W(STEP_W), .CNT_W(CNT_S)) dut_s (
    .clk (clk), .rst_n (rst_n), .cmd (cmd_bus_s.slave), .pc (pc),
    .cpu_en (cpu_en_s), .state (state_s), .halted (halted_s), .bp_hit (bp_hit_s),
    .cmd_err (cmd_err_s), .retired (retired_s)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cpu_pc  = 0;

  int m_state, m_step, m_bp_en, m_bp_addr, m_skip, m_bp_hit, m_cmd_err, m_cnt;

  typedef struct {
    int v; int op; int arg; int pcv;
    int en; int st; int bph; int err; int ret;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_running();
    return int'(m_state == 1 || m_state == 2);
  endfunction

  function automatic int m_bp_now();
    return int'(m_bp_en != 0 && int'(pc) == m_bp_addr && m_skip == 0);
  endfunction

  function automatic int m_cpu_en();
    return int'(m_running() != 0 && m_bp_now() == 0);
  endfunction

  task automatic model_reset();
    m_state = 0; m_step = 0; m_bp_en = 0; m_bp_addr = 0;
    m_skip = 0; m_bp_hit = 0; m_cmd_err = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int run = m_running();
    int hit = m_bp_now();
    int en  = m_cpu_en();
    int o   = cmd_valid ? int'(cmd_op) : 0;
    int arg = int'(cmd_arg);
    int ns  = m_state;
    int err = 0;
    int bph = 0;
    if (en != 0) begin m_cnt++; m_skip = 0; end
    if (o == 6) m_cnt = 0;
    if (o == 7 || (run != 0 && (o == 1 || o == 3)) || (run == 0 && o == 2)) err = 1;
    if (run != 0) begin
      if (o == 2) begin ns = 0; m_step = 0; end
      else if (hit != 0) begin ns = 3; bph = 1; end
      else if (m_state == 2) begin
        if (m_step == 1) ns = 0;
        m_step--;
      end
    end else if (o == 1) begin
      ns = 1; m_skip = 1;
    end else if (o == 3 && arg != 0) begin
      ns = 2; m_step = arg; m_skip = 1;
    end
    if (o == 4) begin m_bp_en = 1; m_bp_addr = arg % 128; end
    if (o == 5) m_bp_en = 0;
    m_state = ns; m_bp_hit = bph; m_cmd_err = err;
  endtask

  task automatic checkOutput();
    int ret   = (m_cnt > 65535) ? 65535 : m_cnt;
    int ret_s = (m_cnt > 15) ? 15 : m_cnt;
    chk("cpu_en", 32'(cpu_en), m_cpu_en());
    chk("state", 32'(state), m_state);
    chk("halted", 32'(halted), int'(m_state == 0 || m_state == 3));
    chk("bp_hit", 32'(bp_hit), m_bp_hit);
    chk("cmd_err", 32'(cmd_err), m_cmd_err);
    chk("retired", 32'(retired), ret);
    chk("cmd_ready", 32'(cmd_bus.cmd_ready), 1);
    chk("retired_s", 32'(retired_s), ret_s);
    chk("cpu_en_s", 32'(cpu_en_s), m_cpu_en());
  endtask

  task automatic applyStimulus(input int v, input int op, input int arg, input int pcv);
    cmd_valid = (v != 0);
    cmd_op    = 3'(op);
    cmd_arg   = 8'(arg);
    pc        = 7'(pcv);
    #4;
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_cpu_en() != 0) cpu_pc++;
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, cpu_pc);
      tick();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = '0; pc = '0;
    #4;
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_halted", 32'(halted), 1);
    chk("rst_bp_hit", 32'(bp_hit), 0);
    chk("rst_cmd_err", 32'(cmd_err), 0);
    chk("rst_retired", 32'(retired), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cpu_pc = 0;
  endtask

  initial begin
    tbl[0]  = '{1, CMD_STEP,    3, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{0, CMD_NOP,     0, 0,  1, 2, 0, 0, 0};
    tbl[2]  = '{0, CMD_NOP,     0, 1,  1, 2, 0, 0, 1};
    tbl[3]  = '{0, CMD_NOP,     0, 2,  1, 2, 0, 0, 2};
    tbl[4]  = '{1, CMD_STEP,    0, 3,  0, 0, 0, 0, 3};
    tbl[5]  = '{1, CMD_HALT,    0, 3,  0, 0, 0, 0, 3};
    tbl[6]  = '{0, CMD_NOP,     0, 3,  0, 0, 0, 1, 3};
    tbl[7]  = '{1, CMD_RUN,     0, 3,  0, 0, 0, 0, 3};
    tbl[8]  = '{1, CMD_RUN,     0, 3,  1, 1, 0, 0, 3};
    tbl[9]  = '{1, CMD_RSVD,    0, 4,  1, 1, 0, 1, 4};
    tbl[10] = '{1, CMD_CLR_CNT, 0, 5,  1, 1, 0, 1, 5};
    tbl[11] = '{1, CMD_HALT,    0, 6,  1, 1, 0, 0, 0};
    tbl[12] = '{0, CMD_NOP,     0, 7,  0, 0, 0, 0, 1};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].v, tbl[i].op, tbl[i].arg, tbl[i].pcv);
      chk($sformatf("vec%0d.cpu_en", i), 32'(cpu_en), tbl[i].en);
      chk($sformatf("vec%0d.state", i), 32'(state), tbl[i].st);
      chk($sformatf("vec%0d.bp_hit", i), 32'(bp_hit), tbl[i].bph);
      chk($sformatf("vec%0d.cmd_err", i), 32'(cmd_err), tbl[i].err);
      chk($sformatf("vec%0d.retired", i), 32'(retired), tbl[i].ret);
      tick();
    end

    // RUN ramp, narrow-counter saturation, CLR_CNT and async reset mid-RUN
    do_reset();
    applyStimulus(1, CMD_RUN, 0, cpu_pc);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, cpu_pc);
      if (i == 0) chk("run_first_en", 32'(cpu_en), 1);
      tick();
    end
    applyStimulus(0, 0, 0, cpu_pc);
    chk("run_ret10", 32'(retired), 10);
    chk("run_state", 32'(state), 1);
    tick();
    idle(9);
    applyStimulus(0, 0, 0, cpu_pc);
    chk("run_ret20", 32'(retired), 20);
    chk("sat_ret_s", 32'(retired_s), 15);
    tick();
    applyStimulus(1, CMD_CLR_CNT, 0, cpu_pc);
    tick();
    applyStimulus(0, 0, 0, cpu_pc);
    chk("clr_cnt_run", 32'(retired), 0);
    tick();
    cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cpu_en", 32'(cpu_en), 0);
    chk("arst_cpu_en_s", 32'(cpu_en_s), 0);
    chk("arst_state", 32'(state), 0);
    chk("arst_halted", 32'(halted), 1);
    chk("arst_retired", 32'(retired), 0);
    chk("arst_retired_s", 32'(retired_s), 0);
    chk("arst_bp_hit", 32'(bp_hit), 0);
    chk("arst_cmd_err", 32'(cmd_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cpu_pc = 0;

    // Breakpoint at 5, then resume past it
    applyStimulus(1, CMD_SET_BP, 5, cpu_pc);
    tick();
    applyStimulus(1, CMD_RUN, 0, cpu_pc);
    tick();
    idle(5);
    applyStimulus(0, 0, 0, cpu_pc);
    chk("bp_pc", cpu_pc, 5);
    chk("bp_cpu_en", 32'(cpu_en), 0);
    tick();
    applyStimulus(0, 0, 0, cpu_pc);
    chk("bp_state", 32'(state), 3);
    chk("bp_hit_pulse", 32'(bp_hit), 1);
    chk("bp_retired", 32'(retired), 5);
    tick();
    applyStimulus(0, 0, 0, cpu_pc);
    chk("bp_hit_once", 32'(bp_hit), 0);
    tick();
    applyStimulus(1, CMD_RUN, 0, cpu_pc);
    chk("resume_accept_en", 32'(cpu_en), 0);
    tick();
    applyStimulus(0, 0, 0, cpu_pc);
    chk("resume_en_at_bp", 32'(cpu_en), 1);
    chk("resume_state", 32'(state), 1);
    tick();
    applyStimulus(0, 0, 0, cpu_pc);
    chk("resume_no_rebreak", 32'(cpu_en), 1);
    tick();
    applyStimulus(1, CMD_HALT, 0, cpu_pc);
    tick();

    // HALT arriving in the breakpoint cycle
    applyStimulus(1, CMD_SET_BP, cpu_pc + 2, cpu_pc);
    tick();
    applyStimulus(1, CMD_RUN, 0, cpu_pc);
    tick();
    idle(2);
    applyStimulus(1, CMD_HALT, 0, cpu_pc);
    chk("halt_bp_en", 32'(cpu_en), 0);
    tick();
    applyStimulus(0, 0, 0, cpu_pc);
    chk("halt_bp_state", 32'(state), 0);
    chk("halt_bp_nohit", 32'(bp_hit), 0);
    tick();

    // HALT during STEP 5 after two retired steps
    applyStimulus(1, CMD_CLR_CNT, 0, cpu_pc);
    tick();
    applyStimulus(1, CMD_CLR_BP, 0, cpu_pc);
    tick();
    applyStimulus(1, CMD_STEP, 5, cpu_pc);
    tick();
    idle(1);
    applyStimulus(1, CMD_HALT, 0, cpu_pc);
    tick();
    applyStimulus(0, 0, 0, cpu_pc);
    chk("step_halt_state", 32'(state), 0);
    chk("step_halt_halted", 32'(halted), 1);
    chk("step_halt_ret", 32'(retired), 2);
    tick();

    // Randomized commands against the reference model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int v, op, arg;
      v   = int'($urandom_range(0, 9) < 3);
      op  = int'($urandom_range(0, 7));
      arg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) cpu_pc = int'($urandom_range(0, 15));
      applyStimulus(v, op, arg, cpu_pc % 16);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_controller.md
Name: exec_controller

Overview:
Run/halt/single-step sequencer for the single-cycle CPU. It generates one clock-enable, cpu_en, which gates the PC load, register loads, status-register update and data-memory write. The CPU therefore advances exactly one instruction per clk edge while cpu_en=1. It accepts debug commands over a valid/ready port, supports one PC breakpoint, and counts retired instructions.

Parameters:
PC_W, 7, width of the CPU program counter and breakpoint address
STEP_W, 8, width of cmd_arg and the step down-counter
CNT_W, 16, width of the retired-instruction counter (saturating)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle (1 whenever rst_n=1)
cmd_op  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 reserved
cmd_arg  in  STEP_W  STEP count; SET_BP address in [PC_W-1:0]
pc  in  PC_W  current CPU program counter
cpu_en  out  1  CPU advance enable (combinational)
state  out  2  0 HALTED, 1 RUN, 2 STEP, 3 BREAK
halted  out  1  state is HALTED or BREAK
bp_hit  out  1  one-cycle pulse, registered, on entry to BREAK
cmd_err  out  1  one-cycle pulse, registered, on an illegal command
retired  out  CNT_W  instructions retired since reset or CLR_CNT

Behaviour:
- Reset, asynchronous, rst_n=0:
  - state=HALTED, cpu_en=0, retired=0, bp_en=0, bp_addr=0.
  - step_cnt=0, skip_bp=0, bp_hit=0, cmd_err=0.
  - Asserting reset mid-RUN drops cpu_en in the same cycle.
- Command acceptance:
  - A command is accepted on any edge where cmd_valid=1. cmd_ready is tied high out of reset.
  - An accepted command changes state on that edge.
  - cpu_en in the accept cycle follows the current state, so the in-flight instruction still retires.
- Breakpoint match: bp_now = bp_en & (pc==bp_addr) & ~skip_bp.
- cpu_en = (state==RUN | state==STEP) & ~bp_now.
- retired increments on every edge with cpu_en=1. It saturates at all-ones. CLR_CNT zeroes it, and CLR_CNT wins over an increment in the same cycle.
- skip_bp:
  - Set on any transition from HALTED/BREAK into RUN or STEP.
  - Cleared on the first edge with cpu_en=1.
  - Effect: resuming from a breakpoint executes the breakpointed instruction.
- Transitions, priority top-down per cycle:
  - Accepted HALT in RUN/STEP -> HALTED. step_cnt cleared.
  - bp_now in RUN/STEP -> BREAK; bp_hit pulses next cycle.
  - STEP with cpu_en=1 and step_cnt==1 -> HALTED. Otherwise step_cnt decrements.
  - Accepted RUN in HALTED/BREAK -> RUN.
  - Accepted STEP n in HALTED/BREAK:
    - n>=1: step_cnt=n, state -> STEP.
    - n==0: accepted as a no-op; no error, state unchanged.
- Legal in any state, no state change:
  - SET_BP: bp_addr=cmd_arg[PC_W-1:0], bp_en=1.
  - CLR_BP: bp_en=0.
  - CLR_CNT, NOP.
  - SET_BP takes effect from the following cycle.
- cmd_err pulses on:
  - RUN or STEP issued while in RUN/STEP;
  - HALT issued while HALTED/BREAK;
  - op 7.
  - The command is dropped and state is unchanged.
- HALT and bp_now in the same cycle: HALT wins; no bp_hit pulse.
- pc values are not checked; pc wrap-around is transparent.

Decomposition:
- Package exec_ctrl_pkg holds:
  - cmd_op encodings (CMD_NOP..CMD_RSVD);
  - state encodings (ST_HALTED, ST_RUN, ST_STEP, ST_BREAK);
  - default widths.
- One sub-module, retire_counter: a CNT_W saturating up-counter with inc and clr inputs, clr priority.
- The FSM, breakpoint compare and step counter stay in exec_controller.

Test Plan:
- Reset, then RUN with pc incrementing 0,1,2,… -> cpu_en=1 from the next cycle; retired=10 after 10 enabled cycles; state=1.
- From HALTED, STEP 3 -> cpu_en high for exactly 3 cycles, then state=0, halted=1, retired=3; STEP 0 -> no cpu_en, no cmd_err.
- SET_BP 0x05, then RUN with pc ramping from 0 -> cpu_en=0 in the cycle pc==5; state=3; bp_hit one pulse; retired=5.
  - Then RUN -> first cycle cpu_en=1 at pc==5, and it does not re-break.
- In RUN issue RUN, then op 7 -> two cmd_err pulses, state stays 1. In HALTED issue HALT -> cmd_err.
- HALT presented in the cycle pc==bp_addr -> state 0, no bp_hit. HALT during STEP 5 after 2 steps -> HALTED, retired=2.
- With CNT_W=4, RUN 20 cycles -> retired=15. CLR_CNT during RUN -> retired=0 that edge. Async reset mid-RUN -> cpu_en=0 immediately and all outputs at reset values.
